// File: rtl/regfile_wb.sv
// regfile_wb
//   32 x DATA_W register file with two combinational read ports, same-cycle
//   write bypass, and a per-register pending scoreboard that flags a stall
//   when a source register still awaits its writeback.
//
// Ports
//   clk           : system clock, all state updates on the rising edge
//   reset         : asynchronous active-high; clears registers, scoreboard, count
//   rs_addr       : read port A index
//   rt_addr       : read port B index
//   rs_data       : read port A data (combinational, bypasses a same-cycle write)
//   rt_data       : read port B data (combinational, bypasses a same-cycle write)
//   wr_addr       : writeback destination index (from the rt/rd select mux)
//   wr_data       : writeback data
//   wr_en         : commit wr_data to wr_addr at the next edge
//   issue_valid   : an instruction claims a destination this cycle
//   issue_addr    : destination being claimed
//   stall         : a read source is pending and not bypassed this cycle
//   pending_count : registered population count of the pending bits (0..31)
module regfile_wb #(
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [4:0]        rs_addr,
   input  logic [4:0]        rt_addr,
   output logic [DATA_W-1:0] rs_data,
   output logic [DATA_W-1:0] rt_data,
   input  logic [4:0]        wr_addr,
   input  logic [DATA_W-1:0] wr_data,
   input  logic              wr_en,
   input  logic              issue_valid,
   input  logic [4:0]        issue_addr,
   output logic              stall,
   output logic [5:0]        pending_count
);

   logic [DATA_W-1:0] mem_q [32];
   logic [DATA_W-1:0] mem_d [32];
   logic [31:0]       pend_q;
   logic [31:0]       pend_d;
   logic [5:0]        count_q;
   logic [5:0]        count_d;

   logic wr_live;
   logic issue_live;
   logic cnt_inc;
   logic cnt_dec;

   assign wr_live    = wr_en && (wr_addr != 5'd0);
   assign issue_live = issue_valid && (issue_addr != 5'd0);

   // Read port value: r0 is hard zero, a write in flight to the same index
   // is forwarded so the reader never sees the stale entry.
   function automatic logic [DATA_W-1:0] read_port(
      input logic [4:0]        addr,
      input logic [DATA_W-1:0] stored,
      input logic              we,
      input logic [4:0]        waddr,
      input logic [DATA_W-1:0] wdata
   );
      if (addr == 5'd0) begin
         return '0;
      end else if (we && (waddr == addr)) begin
         return wdata;
      end else begin
         return stored;
      end
   endfunction

   // A pending source stalls unless its writeback is arriving this cycle.
   function automatic logic src_blocked(
      input logic [4:0] addr,
      input logic       pend_bit,
      input logic       we,
      input logic [4:0] waddr
   );
      return pend_bit && !(we && (waddr == addr));
   endfunction

   assign rs_data = read_port(rs_addr, mem_q[rs_addr], wr_en, wr_addr, wr_data);
   assign rt_data = read_port(rt_addr, mem_q[rt_addr], wr_en, wr_addr, wr_data);

   assign stall = src_blocked(rs_addr, pend_q[rs_addr], wr_en, wr_addr) ||
                  src_blocked(rt_addr, pend_q[rt_addr], wr_en, wr_addr);

   assign pending_count = count_q;

   always_comb begin
      mem_d = mem_q;
      if (wr_live) begin
         mem_d[wr_addr] = wr_data;
      end
   end

   // Clear first, then set, so a claim on the same index as the retiring
   // write keeps the register pending.
   always_comb begin
      pend_d = pend_q;
      if (wr_live) begin
         pend_d[wr_addr] = 1'b0;
      end
      if (issue_live) begin
         pend_d[issue_addr] = 1'b1;
      end
      pend_d[0] = 1'b0;
   end

   // Incremental popcount: at most one bit rises and one bit falls per edge.
   always_comb begin
      cnt_inc = issue_live && !pend_q[issue_addr];
      cnt_dec = wr_live && pend_q[wr_addr] &&
                !(issue_live && (issue_addr == wr_addr));
      count_d = count_q + {5'd0, cnt_inc} - {5'd0, cnt_dec};
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < 32; i++) begin
            mem_q[i] <= '0;
         end
         pend_q  <= '0;
         count_q <= '0;
      end else begin
         for (int i = 1; i < 32; i++) begin
            mem_q[i] <= mem_d[i];
         end
         mem_q[0] <= '0;
         pend_q   <= pend_d;
         count_q  <= count_d;
      end
   end

endmodule

// File: tb/tb_regfile_wb.sv
module tb_regfile_wb;

   localparam int DATA_W = 32;

   logic              clk = 1'b0;
   logic              reset;
   logic [4:0]        rs_addr, rt_addr, wr_addr, issue_addr;
   logic [DATA_W-1:0] rs_data, rt_data, wr_data;
   logic              wr_en, issue_valid, stall;
   logic [5:0]        pending_count;

   int n_chk  = 0;
   int n_fail = 0;

   // Behavioural reference: plain arrays updated once per clock edge.
   logic [31:0] m_mem  [32];
   bit          m_pend [32];

   typedef struct {
      logic [4:0]  rs, rt;
      logic        we;
      logic [4:0]  wa;
      logic [31:0] wd;
      logic        iv;
      logic [4:0]  ia;
      logic [31:0] e_rs, e_rt;
      logic        e_stall;
      logic [5:0]  e_cnt;
   } vec_t;

   vec_t vecs [12];

   regfile_wb #(.DATA_W(DATA_W)) dut (
      .clk(clk), .reset(reset),
      .rs_addr(rs_addr), .rt_addr(rt_addr),
      .rs_data(rs_data), .rt_data(rt_data),
      .wr_addr(wr_addr), .wr_data(wr_data), .wr_en(wr_en),
      .issue_valid(issue_valid), .issue_addr(issue_addr),
      .stall(stall), .pending_count(pending_count)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s actual=%h expected=%h", nm, act, exp);
      end
   endtask

   function automatic logic [31:0] m_read(input logic [4:0] a);
      if (a == 0) return 0;
      if (wr_en && wr_addr == a) return wr_data;
      return m_mem[a];
   endfunction

   function automatic logic m_stall();
      logic s;
      s = 1'b0;
      if (rs_addr != 0 && m_pend[rs_addr] && !(wr_en && wr_addr == rs_addr)) s = 1'b1;
      if (rt_addr != 0 && m_pend[rt_addr] && !(wr_en && wr_addr == rt_addr)) s = 1'b1;
      return s;
   endfunction

   function automatic int m_count();
      int c;
      c = 0;
      foreach (m_pend[i]) if (m_pend[i]) c++;
      return c;
   endfunction

   task automatic m_reset();
      foreach (m_mem[i]) begin
         m_mem[i]  = 0;
         m_pend[i] = 0;
      end
   endtask

   task automatic model_check(input string tag);
      chk({tag, ".rs_data"}, rs_data, m_read(rs_addr));
      chk({tag, ".rt_data"}, rt_data, m_read(rt_addr));
      chk({tag, ".stall"}, {31'd0, stall}, {31'd0, m_stall()});
      chk({tag, ".count"}, {26'd0, pending_count}, m_count());
   endtask

   task automatic set_in(input logic [4:0] rs, input logic [4:0] rt,
                         input logic we, input logic [4:0] wa, input logic [31:0] wd,
                         input logic iv, input logic [4:0] ia);
      rs_addr = rs; rt_addr = rt; wr_en = we; wr_addr = wa; wr_data = wd;
      issue_valid = iv; issue_addr = ia;
   endtask

   // Advance one edge, applying the specification's rules to the model,
   // then return to the falling edge for the next drive.
   task automatic step();
      @(posedge clk);
      if (wr_en && wr_addr != 0) begin
         m_mem[wr_addr]  = wr_data;
         m_pend[wr_addr] = 0;
      end
      if (issue_valid && issue_addr != 0) m_pend[issue_addr] = 1;
      @(negedge clk);
   endtask

   initial begin
      vecs[0]  = '{5'd5, 5'd0, 1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 32'hDEADBEEF, 32'h0, 1'b0, 6'd0};
      vecs[1]  = '{5'd5, 5'd7, 1'b1, 5'd7, 32'h12345678, 1'b0, 5'd0, 32'hDEADBEEF, 32'h12345678, 1'b0, 6'd0};
      vecs[2]  = '{5'd0, 5'd0, 1'b1, 5'd0, 32'hFFFFFFFF, 1'b1, 5'd0, 32'h0, 32'h0, 1'b0, 6'd0};
      vecs[3]  = '{5'd0, 5'd7, 1'b0, 5'd0, 32'h0, 1'b1, 5'd9, 32'h0, 32'h12345678, 1'b0, 6'd0};
      vecs[4]  = '{5'd9, 5'd5, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 32'hDEADBEEF, 1'b1, 6'd1};
      vecs[5]  = '{5'd9, 5'd0, 1'b1, 5'd9, 32'hA5A5A5A5, 1'b0, 5'd0, 32'hA5A5A5A5, 32'h0, 1'b0, 6'd1};
      vecs[6]  = '{5'd9, 5'd9, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'hA5A5A5A5, 32'hA5A5A5A5, 1'b0, 6'd0};
      vecs[7]  = '{5'd3, 5'd0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd3, 32'h0, 32'h0, 1'b0, 6'd0};
      vecs[8]  = '{5'd3, 5'd0, 1'b1, 5'd3, 32'h55AA00FF, 1'b1, 5'd3, 32'h55AA00FF, 32'h0, 1'b0, 6'd1};
      vecs[9]  = '{5'd3, 5'd3, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h55AA00FF, 32'h55AA00FF, 1'b1, 6'd1};
      vecs[10] = '{5'd3, 5'd0, 1'b1, 5'd3, 32'h00000011, 1'b0, 5'd0, 32'h00000011, 32'h0, 1'b0, 6'd1};
      vecs[11] = '{5'd3, 5'd0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h00000011, 32'h0, 1'b0, 6'd0};

      reset = 1'b1;
      set_in(5'd5, 5'd9, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0);
      m_reset();
      repeat (2) @(negedge clk);
      chk("reset.rs_data", rs_data, 32'h0);
      chk("reset.rt_data", rt_data, 32'h0);
      chk("reset.stall", {31'd0, stall}, 32'h0);
      chk("reset.count", {26'd0, pending_count}, 32'h0);
      reset = 1'b0;

      // Directed vectors: outputs checked before each edge.
      for (int i = 0; i < 12; i++) begin
         set_in(vecs[i].rs, vecs[i].rt, vecs[i].we, vecs[i].wa, vecs[i].wd, vecs[i].iv, vecs[i].ia);
         #1;
         chk($sformatf("vec%0d.rs_data", i), rs_data, vecs[i].e_rs);
         chk($sformatf("vec%0d.rt_data", i), rt_data, vecs[i].e_rt);
         chk($sformatf("vec%0d.stall", i), {31'd0, stall}, {31'd0, vecs[i].e_stall});
         chk($sformatf("vec%0d.count", i), {26'd0, pending_count}, {26'd0, vecs[i].e_cnt});
         step();
      end

      // Mid-cycle reset: r10 pending, r5 holds DEADBEEF, then reset asynchronously.
      set_in(5'd0, 5'd0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd10);
      step();
      set_in(5'd5, 5'd10, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0);
      #1;
      model_check("prereset");
      #2 reset = 1'b1;
      #1;
      m_reset();
      chk("midreset.rs_data", rs_data, 32'h0);
      chk("midreset.count", {26'd0, pending_count}, 32'h0);
      chk("midreset.stall", {31'd0, stall}, 32'h0);
      // Write and issue presented while reset is held must not survive.
      set_in(5'd5, 5'd6, 1'b1, 5'd5, 32'hCAFEF00D, 1'b1, 5'd6);
      @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      set_in(5'd5, 5'd6, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0);
      #1;
      chk("postreset.rs_data", rs_data, 32'h0);
      chk("postreset.stall", {31'd0, stall}, 32'h0);
      chk("postreset.count", {26'd0, pending_count}, 32'h0);

      // Fill the scoreboard, re-issue r4, then drain it.
      for (int r = 1; r < 32; r++) begin
         set_in(5'(r), 5'd0, 1'b0, 5'd0, 32'h0, 1'b1, 5'(r));
         step();
      end
      set_in(5'd4, 5'd31, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0);
      #1;
      chk("fill.count", {26'd0, pending_count}, 32'd31);
      chk("fill.stall", {31'd0, stall}, 32'h1);
      set_in(5'd4, 5'd0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd4);
      step();
      chk("reissue.count", {26'd0, pending_count}, 32'd31);
      for (int r = 1; r < 32; r++) begin
         set_in(5'(r), 5'((r % 31) + 1), 1'b1, 5'(r), 32'h1000 + r, 1'b0, 5'd0);
         #1;
         model_check($sformatf("drain%0d", r));
         step();
      end
      chk("drain.count", {26'd0, pending_count}, 32'd0);

      // Randomized traffic over a narrow index range to force collisions.
      for (int c = 0; c < 400; c++) begin
         set_in(5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), $urandom,
                1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)));
         #1;
         model_check($sformatf("rand%0d", c));
         step();
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
